// File: rtl/usb3300_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : usb3300_rx_framer
// Description : Captures ULPI receive traffic from a USB3300 PHY into a small
//               FIFO and streams it to a byte-wide UART transmitter, either as
//               raw bytes or as two ASCII hex characters per byte, with a
//               configurable end-of-packet character.
// Revision    : 1.0 - initial release
// ============================================================================
module usb3300_rx_framer #(
    parameter int         DEPTH       = 16,
    parameter bit         HEX_MODE    = 1'b1,
    parameter bit         CAPTURE_CMD = 1'b0,
    parameter logic [7:0] EOP_CHAR    = 8'h0A
) (
    input  logic                     clk_ext,
    input  logic                     rstn,
    input  logic [7:0]               DATA,
    input  logic                     DIR,
    input  logic                     NXT,
    input  logic                     TiP,
    output logic [7:0]               Tx_data,
    output logic                     send_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               ovf_cnt,
    output logic [15:0]              pkt_cnt
);

    localparam int c_AW = $clog2(DEPTH);   // pointer width
    localparam int c_LW = c_AW + 1;        // occupancy width
    localparam int c_SW = c_LW + 1;        // free-space arithmetic width

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SEND_HI = 3'd2,
        S_WAIT_HI = 3'd3,
        S_SEND_LO = 3'd4,
        S_WAIT_LO = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Capture side
    // ------------------------------------------------------------------
    logic             r_dir_q;
    logic             r_pkt_active;
    logic             r_eop_pend;
    logic [7:0]       r_ovf;
    logic [15:0]      r_pkt;

    logic             w_rx_cycle;
    logic             w_data;
    logic             w_cmd;
    logic             w_eop_fall;
    logic             w_eop_cmd;
    logic             w_eop_now;
    logic             w_cur_push;
    logic [8:0]       w_cur_entry;

    // The first DIR-high cycle (dir_q still low) is bus turnaround and is
    // never sampled; only cycles with DIR held high carry receive traffic.
    assign w_rx_cycle  = DIR & r_dir_q;
    assign w_data      = w_rx_cycle & NXT;
    assign w_cmd       = w_rx_cycle & ~NXT;
    assign w_eop_fall  = r_pkt_active & ~DIR & r_dir_q;
    assign w_eop_cmd   = r_pkt_active & w_cmd & ~DATA[4];
    // A command byte that ends a packet is itself captured when CAPTURE_CMD
    // is set, so its EOP has to be deferred one cycle into r_eop_pend.
    assign w_eop_now   = w_eop_fall | (w_eop_cmd & ~CAPTURE_CMD);
    assign w_cur_push  = w_data | (w_cmd & CAPTURE_CMD) | w_eop_now;
    assign w_cur_entry = w_eop_now ? 9'h100 : {1'b0, DATA};

    // ------------------------------------------------------------------
    // FIFO: up to two writes per cycle (deferred EOP first, then the
    // current capture) so capture never stalls.
    // ------------------------------------------------------------------
    logic [8:0]       r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;

    logic             w_pop;
    logic [c_SW-1:0]  w_space;
    logic             w_has1;
    logic             w_has2;
    logic             w_req_a;
    logic             w_req_b;
    logic [8:0]       w_ent_a;
    logic             w_ok_a;
    logic             w_ok_b;
    logic [1:0]       w_n_wr;
    logic [1:0]       w_n_drop;
    logic [8:0]       w_ovf_sum;
    logic [8:0]       w_rd_entry;

    assign w_space    = c_SW'(DEPTH) - c_SW'(r_level) + c_SW'(w_pop);
    assign w_has1     = (w_space != '0);
    assign w_has2     = (w_space[c_SW-1:1] != '0);
    assign w_req_a    = r_eop_pend | w_cur_push;
    assign w_req_b    = r_eop_pend & w_cur_push;
    assign w_ent_a    = r_eop_pend ? 9'h100 : w_cur_entry;
    assign w_ok_a     = w_req_a & w_has1;
    assign w_ok_b     = w_req_b & w_has2;
    assign w_n_wr     = {1'b0, w_ok_a} + {1'b0, w_ok_b};
    assign w_n_drop   = {1'b0, w_req_a & ~w_ok_a} + {1'b0, w_req_b & ~w_ok_b};
    assign w_ovf_sum  = {1'b0, r_ovf} + {7'd0, w_n_drop};
    assign w_rd_entry = r_mem[r_rd_ptr];

    // Capture state, packet counter and overflow counter
    always_ff @(posedge clk_ext) begin
        if (!rstn) begin
            r_dir_q      <= 1'b0;
            r_pkt_active <= 1'b0;
            r_eop_pend   <= 1'b0;
            r_ovf        <= 8'd0;
            r_pkt        <= 16'd0;
        end else begin
            r_dir_q    <= DIR;
            r_eop_pend <= w_eop_cmd & CAPTURE_CMD;
            if (w_eop_fall | w_eop_cmd) begin
                r_pkt_active <= 1'b0;
                r_pkt        <= r_pkt + 16'd1;
            end else if (w_data) begin
                r_pkt_active <= 1'b1;
            end
            r_ovf <= w_ovf_sum[8] ? 8'hFF : w_ovf_sum[7:0];
        end
    end

    // FIFO storage writes (no reset: contents are qualified by the pointers)
    always_ff @(posedge clk_ext) begin
        if (w_ok_a) begin
            r_mem[r_wr_ptr] <= w_ent_a;
        end
        if (w_ok_b) begin
            r_mem[r_wr_ptr + c_AW'(1)] <= w_cur_entry;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_ext) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_AW'(w_n_wr);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_level <= r_level + c_LW'(w_n_wr) - c_LW'(w_pop);
        end
    end

    // ------------------------------------------------------------------
    // Output side
    // ------------------------------------------------------------------
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [8:0]  r_hold;
    logic [7:0]  r_tx;
    logic        r_seen;
    logic [9:0]  r_timer;
    logic [7:0]  w_tx_first;

    assign w_pop      = (r_state == S_LOAD);
    assign w_tx_first = w_rd_entry[8] ? EOP_CHAR
                      : (HEX_MODE ? hex_char(w_rd_entry[7:4]) : w_rd_entry[7:0]);

    // Next-state and start-pulse decode; the pulse is held off while TiP
    // is high so the UART is never started mid-character.
    always_comb begin
        w_next    = r_state;
        send_data = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_level != '0) && !TiP) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_next = S_SEND_HI;
            end
            S_SEND_HI: begin
                if (!TiP) begin
                    send_data = 1'b1;
                    w_next    = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (r_seen && !TiP) begin
                    w_next = (HEX_MODE && !r_hold[8]) ? S_SEND_LO : S_IDLE;
                end else if (!r_seen && !TiP && (r_timer == 10'h3FF)) begin
                    w_next = S_SEND_HI;
                end
            end
            S_SEND_LO: begin
                if (!TiP) begin
                    send_data = 1'b1;
                    w_next    = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (r_seen && !TiP) begin
                    w_next = S_IDLE;
                end else if (!r_seen && !TiP && (r_timer == 10'h3FF)) begin
                    w_next = S_SEND_LO;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register, holding register, UART byte and handshake timer
    always_ff @(posedge clk_ext) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_hold  <= 9'd0;
            r_tx    <= 8'h00;
            r_seen  <= 1'b0;
            r_timer <= 10'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_LOAD: begin
                    r_hold <= w_rd_entry;
                    r_tx   <= w_tx_first;
                end
                S_SEND_HI, S_SEND_LO: begin
                    r_seen  <= 1'b0;
                    r_timer <= 10'd0;
                end
                S_WAIT_HI, S_WAIT_LO: begin
                    if (TiP) begin
                        r_seen <= 1'b1;
                    end else if (!r_seen) begin
                        r_timer <= r_timer + 10'd1;
                    end
                end
                default: begin
                end
            endcase
            if ((r_state == S_WAIT_HI) && (w_next == S_SEND_LO)) begin
                r_tx <= hex_char(r_hold[3:0]);
            end
        end
    end

    assign Tx_data    = r_tx;
    assign fifo_level = r_level;
    assign ovf_cnt    = r_ovf;
    assign pkt_cnt    = r_pkt;

endmodule
`default_nettype wire

// File: tb/tb_usb3300_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb3300_rx_framer
// Description : Directed self-checking bench. Instance A uses the default
//               parameters; instance B is DEPTH=4, raw bytes, RX CMD capture.
//               Each instance has a small UART model (normal/held/mute).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb3300_rx_framer;

    logic        clk_ext = 1'b0;
    logic        rstn_a  = 1'b0;
    logic        rstn_b  = 1'b0;
    logic [7:0]  DATA    = 8'h00;
    logic        DIR     = 1'b0;
    logic        NXT     = 1'b0;
    logic        tip_a   = 1'b0;
    logic        tip_b   = 1'b0;
    logic [7:0]  tx_a, tx_b;
    logic        send_a, send_b;
    logic [4:0]  lvl_a;
    logic [2:0]  lvl_b;
    logic [7:0]  ovf_a, ovf_b;
    logic [15:0] pkt_a, pkt_b;

    int mode_a = 0;   // 0 normal UART, 1 TiP held high, 2 TiP never rises
    int mode_b = 1;
    int cnt_a  = 0;
    int cnt_b  = 0;
    int cycn   = 0;
    int viol   = 0;
    int checks   = 0;
    int failures = 0;

    logic [7:0] rx_a[$];
    logic [7:0] rx_b[$];
    int         t_a[$];

    always #5 clk_ext = ~clk_ext;

    usb3300_rx_framer u_a (
        .clk_ext(clk_ext), .rstn(rstn_a), .DATA(DATA), .DIR(DIR), .NXT(NXT),
        .TiP(tip_a), .Tx_data(tx_a), .send_data(send_a), .fifo_level(lvl_a),
        .ovf_cnt(ovf_a), .pkt_cnt(pkt_a)
    );

    usb3300_rx_framer #(.DEPTH(4), .HEX_MODE(1'b0), .CAPTURE_CMD(1'b1)) u_b (
        .clk_ext(clk_ext), .rstn(rstn_b), .DATA(DATA), .DIR(DIR), .NXT(NXT),
        .TiP(tip_b), .Tx_data(tx_b), .send_data(send_b), .fifo_level(lvl_b),
        .ovf_cnt(ovf_b), .pkt_cnt(pkt_b)
    );

    // UART models: 10-cycle TiP per started character, byte log per instance
    always @(posedge clk_ext) begin
        cycn <= cycn + 1;
        if (send_a) begin
            rx_a.push_back(tx_a);
            t_a.push_back(cycn);
            if (tip_a) viol <= viol + 1;
        end
        if (send_b) begin
            rx_b.push_back(tx_b);
            if (tip_b) viol <= viol + 1;
        end
        if (mode_a == 1)      begin tip_a <= 1'b1; cnt_a <= 0; end
        else if (mode_a == 2) begin tip_a <= 1'b0; cnt_a <= 0; end
        else if (send_a)      begin tip_a <= 1'b1; cnt_a <= 10; end
        else if (cnt_a > 1)   begin cnt_a <= cnt_a - 1; end
        else                  begin cnt_a <= 0; tip_a <= 1'b0; end
        if (mode_b == 1)      begin tip_b <= 1'b1; cnt_b <= 0; end
        else if (mode_b == 2) begin tip_b <= 1'b0; cnt_b <= 0; end
        else if (send_b)      begin tip_b <= 1'b1; cnt_b <= 10; end
        else if (cnt_b > 1)   begin cnt_b <= cnt_b - 1; end
        else                  begin cnt_b <= 0; tip_b <= 1'b0; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic d, input logic n, input logic [7:0] x);
        DIR = d; NXT = n; DATA = x;
        @(negedge clk_ext);
    endtask

    task automatic idle(input int n);
        repeat (n) bus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_rx_a(input int n, input int budget);
        int k = 0;
        while (rx_a.size() < n && k < budget) begin @(negedge clk_ext); k++; end
        chk("wait_a", 32'(rx_a.size() >= n), 32'd1);
    endtask

    task automatic wait_rx_b(input int n, input int budget);
        int k = 0;
        while (rx_b.size() < n && k < budget) begin @(negedge clk_ext); k++; end
        chk("wait_b", 32'(rx_b.size() >= n), 32'd1);
    endtask

    function automatic logic [7:0] qa(input int i);
        return (i < rx_a.size()) ? rx_a[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] qb(input int i);
        return (i < rx_b.size()) ? rx_b[i] : 8'hxx;
    endfunction

    initial begin
        // Reset values
        repeat (3) @(negedge clk_ext);
        chk("rst_level", 32'(lvl_a), 32'd0);
        chk("rst_ovf",   32'(ovf_a), 32'd0);
        chk("rst_pkt",   32'(pkt_a), 32'd0);
        chk("rst_send",  32'(send_a), 32'd0);
        chk("rst_tx",    32'(tx_a), 32'h00);

        // Basic hex packet C3 5A
        rstn_a = 1'b1;
        bus(1, 0, 8'h00);
        bus(1, 1, 8'hC3);
        bus(1, 1, 8'h5A);
        bus(0, 0, 8'h00);
        wait_rx_a(5, 400);
        chk("pkt1_b0", 32'(qa(0)), 32'h43);
        chk("pkt1_b1", 32'(qa(1)), 32'h33);
        chk("pkt1_b2", 32'(qa(2)), 32'h35);
        chk("pkt1_b3", 32'(qa(3)), 32'h41);
        chk("pkt1_b4", 32'(qa(4)), 32'h0A);
        chk("pkt1_cnt", 32'(pkt_a), 32'd1);
        idle(20);
        chk("pkt1_level", 32'(lvl_a), 32'd0);

        // RX CMD with RxActive=1 skipped, RxActive=0 ends packet, single EOP
        rx_a.delete();
        bus(1, 0, 8'h00);
        bus(1, 1, 8'h11);
        bus(1, 0, 8'h1E);
        bus(1, 1, 8'h22);
        bus(1, 0, 8'h0E);
        bus(1, 0, 8'h0E);
        bus(0, 0, 8'h00);
        wait_rx_a(5, 400);
        chk("cmd_b0", 32'(qa(0)), 32'h31);
        chk("cmd_b1", 32'(qa(1)), 32'h31);
        chk("cmd_b2", 32'(qa(2)), 32'h32);
        chk("cmd_b3", 32'(qa(3)), 32'h32);
        chk("cmd_b4", 32'(qa(4)), 32'h0A);
        idle(60);
        chk("cmd_count", 32'(rx_a.size()), 32'd5);
        chk("cmd_pkt", 32'(pkt_a), 32'd2);

        // Overflow: DEPTH=4, TiP held, 6 data bytes + EOP
        rstn_a = 1'b0;
        rstn_b = 1'b1;
        bus(1, 0, 8'h00);
        for (int i = 0; i < 6; i++) bus(1, 1, 8'(8'h10 + i));
        bus(0, 0, 8'h00);
        idle(2);
        chk("ovf_level", 32'(lvl_b), 32'd4);
        chk("ovf_cnt",   32'(ovf_b), 32'd3);
        chk("ovf_pkt",   32'(pkt_b), 32'd1);
        chk("ovf_nosend", 32'(rx_b.size()), 32'd0);

        // Raw mode FF, captured terminating RX CMD, deferred EOP
        rstn_b = 1'b0;
        idle(2);
        chk("b_rst_level", 32'(lvl_b), 32'd0);
        chk("b_rst_ovf",   32'(ovf_b), 32'd0);
        mode_b = 0;
        idle(2);
        rstn_b = 1'b1;
        bus(1, 0, 8'h00);
        bus(1, 1, 8'hFF);
        bus(1, 0, 8'h0E);
        bus(0, 0, 8'h00);
        wait_rx_b(3, 300);
        chk("raw_b0", 32'(qb(0)), 32'hFF);
        chk("raw_b1", 32'(qb(1)), 32'h0E);
        chk("raw_b2", 32'(qb(2)), 32'h0A);
        idle(40);
        chk("raw_count", 32'(rx_b.size()), 32'd3);
        chk("raw_pkt", 32'(pkt_b), 32'd1);
        rstn_b = 1'b0;

        // Resend after timeout when TiP never rises
        mode_a = 2;
        idle(2);
        rstn_a = 1'b1;
        rx_a.delete();
        t_a.delete();
        bus(1, 0, 8'h00);
        bus(1, 1, 8'h7E);
        bus(0, 0, 8'h00);
        wait_rx_a(2, 1300);
        chk("tmo_first",  32'(qa(0)), 32'h37);
        chk("tmo_resend", 32'(qa(1)), 32'h37);
        chk("tmo_gap", 32'((t_a.size() >= 2) && (t_a[1] - t_a[0] >= 1024) && (t_a[1] - t_a[0] <= 1026)), 32'd1);
        rstn_a = 1'b0;
        mode_a = 1;
        idle(2);

        // Reset mid-packet with 3 entries queued
        rstn_a = 1'b1;
        bus(1, 0, 8'h00);
        bus(1, 1, 8'hA1);
        bus(1, 1, 8'hB2);
        bus(1, 1, 8'hC3);
        chk("mid_level", 32'(lvl_a), 32'd3);
        rstn_a = 1'b0;
        bus(1, 0, 8'h00);
        bus(1, 0, 8'h00);
        chk("mid_rst_level", 32'(lvl_a), 32'd0);
        rx_a.delete();
        mode_a = 0;
        rstn_a = 1'b1;
        bus(1, 0, 8'h00);
        bus(1, 0, 8'h00);
        bus(1, 0, 8'h00);
        idle(50);
        chk("mid_nosend", 32'(rx_a.size()), 32'd0);
        chk("mid_level2", 32'(lvl_a), 32'd0);
        bus(1, 0, 8'h00);
        bus(1, 1, 8'h4D);
        bus(0, 0, 8'h00);
        wait_rx_a(3, 300);
        chk("new_b0", 32'(qa(0)), 32'h34);
        chk("new_b1", 32'(qa(1)), 32'h44);
        chk("new_b2", 32'(qa(2)), 32'h0A);
        chk("new_pkt", 32'(pkt_a), 32'd1);

        chk("send_while_tip", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
